// File: rtl/arc4_encrypt.sv
// -----------------------------------------------------------------------------
// arc4_encrypt
//
// ARC4 stream-cipher encryptor. On a start request it latches a 24-bit key,
// builds the ARC4 permutation in an external 256x8 S RAM (identity fill, then
// key schedule), reads a length-prefixed plaintext from PT RAM and writes the
// length-prefixed ciphertext to CT RAM. All three RAMs are synchronous
// single-port: read data is valid one cycle after the address is presented,
// so every read is address / wait / capture.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         start request, sampled only while rdy=1
//   rdy        1 = idle and able to accept en
//   key        cipher key, key[23:16] is key byte 0, key[7:0] is key byte 2
//   s_addr     S RAM address
//   s_wrdata   S RAM write data
//   s_rddata   S RAM read data
//   s_wren     S RAM write enable
//   pt_addr    plaintext RAM address (read only)
//   pt_rddata  plaintext RAM read data
//   ct_addr    ciphertext RAM address (write only)
//   ct_wrdata  ciphertext RAM write data
//   ct_wren    ciphertext RAM write enable
//
// State table
//   ST_IDLE    | waiting for en, rdy=1
//   ST_INIT    | S[i]=i, one write per cycle, 256 cycles
//   ST_KSA_RD  | present S[i] address
//   ST_KSA_RW  | wait for S[i]
//   ST_KSA_J   | capture S[i], j += S[i]+key byte, present S[j] address
//   ST_KSA_JW  | wait for S[j]
//   ST_KSA_SWI | capture S[j], write S[i]=old S[j]
//   ST_KSA_SWJ | write S[j]=old S[i], advance i
//   ST_LEN_RD  | present PT[0] address
//   ST_LEN_W   | wait for PT[0]
//   ST_LEN_WR  | capture L, write CT[0]=L
//   ST_PR_RD   | i += 1, present S[i] and PT[k] addresses
//   ST_PR_RW   | wait for S[i], PT[k]
//   ST_PR_J    | capture S[i], PT[k], j += S[i], present S[j] address
//   ST_PR_JW   | wait for S[j]
//   ST_PR_SWI  | capture S[j], write S[i]=old S[j]
//   ST_PR_SWJ  | write S[j]=old S[i]
//   ST_PR_PAD  | present S[S[i]+S[j]] address
//   ST_PR_PW   | wait for pad
//   ST_PR_CT   | write CT[k]=PT[k]^pad, next k or finish
//   ST_FIN     | last CT write commits, rdy rises
// -----------------------------------------------------------------------------
module arc4_encrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  input  logic [7:0]  s_rddata,
  output logic        s_wren,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RD,
    ST_KSA_RW,
    ST_KSA_J,
    ST_KSA_JW,
    ST_KSA_SWI,
    ST_KSA_SWJ,
    ST_LEN_RD,
    ST_LEN_W,
    ST_LEN_WR,
    ST_PR_RD,
    ST_PR_RW,
    ST_PR_J,
    ST_PR_JW,
    ST_PR_SWI,
    ST_PR_SWJ,
    ST_PR_PAD,
    ST_PR_PW,
    ST_PR_CT,
    ST_FIN
  } state_t;

  state_t      state_q;
  logic [23:0] key_q;
  logic [7:0]  i_q;
  logic [7:0]  j_q;
  // 9 bits so that k can reach L=255 and still compare cleanly
  logic [8:0]  k_q;
  logic [7:0]  len_q;
  // i mod 3, tracked alongside i during the key schedule
  logic [1:0]  km_q;
  logic [7:0]  si_q;
  logic [7:0]  sj_q;
  logic [7:0]  ptb_q;

  logic        rdy_q;
  logic [7:0]  s_addr_q;
  logic [7:0]  s_wrdata_q;
  logic        s_wren_q;
  logic [7:0]  pt_addr_q;
  logic [7:0]  ct_addr_q;
  logic [7:0]  ct_wrdata_q;
  logic        ct_wren_q;

  logic [7:0]  key_byte;
  logic [7:0]  j_ksa_d;
  logic [7:0]  j_prga_d;
  logic [7:0]  i_inc_d;
  logic [1:0]  km_d;

  always_comb begin
    key_byte = key_q[23:16];
    case (km_q)
      2'd1:    key_byte = key_q[15:8];
      2'd2:    key_byte = key_q[7:0];
      default: key_byte = key_q[23:16];
    endcase
    j_ksa_d  = j_q + s_rddata + key_byte;
    j_prga_d = j_q + s_rddata;
    i_inc_d  = i_q + 8'd1;
    km_d     = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      km_q        <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      ptb_q       <= '0;
      rdy_q       <= 1'b1;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      pt_addr_q   <= '0;
      ct_addr_q   <= '0;
      ct_wrdata_q <= '0;
      ct_wren_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            key_q   <= key;
            rdy_q   <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            state_q <= ST_INIT;
          end
        end

        ST_INIT: begin
          s_addr_q   <= i_q;
          s_wrdata_q <= i_q;
          s_wren_q   <= 1'b1;
          i_q        <= i_inc_d;
          if (i_q == 8'hFF) begin
            j_q     <= '0;
            km_q    <= '0;
            state_q <= ST_KSA_RD;
          end
        end

        // The last INIT write / previous swap write is still on the port
        // during this cycle; the new read address replaces it on this edge.
        ST_KSA_RD: begin
          s_wren_q <= 1'b0;
          s_addr_q <= i_q;
          state_q  <= ST_KSA_RW;
        end

        ST_KSA_RW: state_q <= ST_KSA_J;

        ST_KSA_J: begin
          si_q     <= s_rddata;
          j_q      <= j_ksa_d;
          s_addr_q <= j_ksa_d;
          state_q  <= ST_KSA_JW;
        end

        ST_KSA_JW: state_q <= ST_KSA_SWI;

        // When i == j both writes store the same value, leaving S unchanged.
        ST_KSA_SWI: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= ST_KSA_SWJ;
        end

        ST_KSA_SWJ: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          i_q        <= i_inc_d;
          km_q       <= km_d;
          state_q    <= (i_q == 8'hFF) ? ST_LEN_RD : ST_KSA_RD;
        end

        ST_LEN_RD: begin
          s_wren_q  <= 1'b0;
          pt_addr_q <= '0;
          state_q   <= ST_LEN_W;
        end

        ST_LEN_W: state_q <= ST_LEN_WR;

        ST_LEN_WR: begin
          len_q       <= pt_rddata;
          ct_addr_q   <= '0;
          ct_wrdata_q <= pt_rddata;
          ct_wren_q   <= 1'b1;
          i_q         <= '0;
          j_q         <= '0;
          k_q         <= 9'd1;
          state_q     <= (pt_rddata == 8'd0) ? ST_FIN : ST_PR_RD;
        end

        // S[i] and PT[k] are fetched in parallel from separate RAMs.
        ST_PR_RD: begin
          ct_wren_q <= 1'b0;
          s_wren_q  <= 1'b0;
          i_q       <= i_inc_d;
          s_addr_q  <= i_inc_d;
          pt_addr_q <= k_q[7:0];
          state_q   <= ST_PR_RW;
        end

        ST_PR_RW: state_q <= ST_PR_J;

        ST_PR_J: begin
          si_q     <= s_rddata;
          ptb_q    <= pt_rddata;
          j_q      <= j_prga_d;
          s_addr_q <= j_prga_d;
          state_q  <= ST_PR_JW;
        end

        ST_PR_JW: state_q <= ST_PR_SWI;

        ST_PR_SWI: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= ST_PR_SWJ;
        end

        ST_PR_SWJ: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          state_q    <= ST_PR_PAD;
        end

        // Post-swap S[i]+S[j] equals pre-swap S[j]+S[i], so the captured
        // values serve directly; the swap-j write commits on this edge.
        ST_PR_PAD: begin
          s_wren_q <= 1'b0;
          s_addr_q <= si_q + sj_q;
          state_q  <= ST_PR_PW;
        end

        ST_PR_PW: state_q <= ST_PR_CT;

        ST_PR_CT: begin
          ct_addr_q   <= k_q[7:0];
          ct_wrdata_q <= ptb_q ^ s_rddata;
          ct_wren_q   <= 1'b1;
          if (k_q == {1'b0, len_q}) begin
            state_q <= ST_FIN;
          end else begin
            k_q     <= k_q + 9'd1;
            state_q <= ST_PR_RD;
          end
        end

        // The final CT write commits on the same edge that raises rdy.
        ST_FIN: begin
          ct_wren_q <= 1'b0;
          rdy_q     <= 1'b1;
          state_q   <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;

endmodule
